game_sprite_motion_ctrl: RTL and testbench

- Per-sprite position/velocity engine for the 2D game; one instance per sprite (player, meteor, bullet).
- Generalises the single-mode sprite control with a runtime mode select, saturating lane clamps, an explicit bullet launch/flight state machine, and off-screen detection.
- Outputs x/y to the sprite renderer, plus active/offscreen status to game control.

---
 rtl/game_sprite_motion_ctrl_if.sv | 34 +++
 rtl/game_sprite_motion_ctrl.sv | 167 ++++++++++++++++
 tb/tb_game_sprite_motion_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/game_sprite_motion_ctrl_if.sv
// Sprite motion bus: load/control inputs from game logic plus position and
// status outputs to the renderer and game control. The bench or game logic
// connects to the master modport; the motion engine connects to the slave modport.
interface game_sprite_motion_ctrl_if #(
  parameter int W_X      = 10,
  parameter int W_Y      = 9,
  parameter int DX_WIDTH = 4,
  parameter int DY_WIDTH = 4
);
  logic [1:0]          mode;
  logic                load_xy;
  logic [W_X-1:0]      load_x;
  logic [W_Y-1:0]      load_y;
  logic                load_dxy;
  logic [DX_WIDTH-1:0] load_dx;
  logic [DY_WIDTH-1:0] load_dy;
  logic                enable;
  logic                fire;
  logic [W_X-1:0]      x;
  logic [W_Y-1:0]      y;
  logic                active;
  logic                flying;
  logic                offscreen;

  modport master (
    output mode, load_xy, load_x, load_y, load_dxy, load_dx, load_dy, enable, fire,
    input  x, y, active, flying, offscreen
  );

  modport slave (
    input  mode, load_xy, load_x, load_y, load_dxy, load_dx, load_dy, enable, fire,
    output x, y, active, flying, offscreen
  );
endinterface

// File: rtl/game_sprite_motion_ctrl.sv
// Per-sprite position/velocity engine: player lane motion with saturating
// clamps, meteor fall with off-screen detection, and a bullet launch/flight
// state machine. Motion advances once per internal strobe tick.
// Optional feature macro: GAME_SPRITE_METEOR_WRAP_EN (meteors leaving the
// bottom of the screen wrap to the top instead of finishing).
module game_sprite_motion_ctrl #(
  parameter int DX_WIDTH      = 4,
  parameter int DY_WIDTH      = 4,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int W_X           = $clog2(SCREEN_WIDTH),
  parameter int W_Y           = $clog2(SCREEN_HEIGHT),
  parameter int X_MIN         = 192,
  parameter int X_MAX         = 430,
  parameter int BULLET_SPEED  = 3,
  parameter int STROBE_WIDTH  = 20
) (
  input logic                      clk,
  input logic                      rst,
  game_sprite_motion_ctrl_if.slave bus
);

  // Two guard bits so sums with a negative velocity stay representable.
  localparam int XS = W_X + 2;
  localparam int YS = W_Y + 2;
  localparam logic signed [XS-1:0] X_LO = XS'(X_MIN);
  localparam logic signed [XS-1:0] X_HI = XS'(X_MAX);
  localparam logic signed [YS-1:0] Y_LIM = YS'(SCREEN_HEIGHT);
  localparam logic [W_Y-1:0] B_SPEED = W_Y'(BULLET_SPEED);

  typedef enum logic [1:0] {IDLE, ARMED, FLYING, DONE} state_t;

  state_t                  state;
  logic [STROBE_WIDTH-1:0] tick_cnt;
  logic                    tick;
  logic [W_X-1:0]          x_reg;
  logic [W_Y-1:0]          y_reg;
  logic [DX_WIDTH-1:0]     dx_reg;
  logic [DY_WIDTH-1:0]     dy_reg;
  logic                    fire_pending;
  logic                    active_reg;
  logic                    flying_reg;
  logic                    offscreen_reg;

  logic signed [XS-1:0]    x_sum;
  logic [W_X-1:0]          x_clamped;
  logic signed [YS-1:0]    y_sum;
  logic                    y_off_top;
  logic                    y_off_bottom;
  logic                    move;
`ifdef GAME_SPRITE_METEOR_WRAP_EN
  logic [W_Y-1:0]          y_wrap;
`endif

  // Free-running strobe divider; the tick fires when the counter is all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt <= '0;
    else     tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = &tick_cnt;
  assign move = tick & bus.enable;

  // Candidate next positions: clamped lane move for x, raw fall for y.
  always_comb begin
    x_sum = $signed({2'b00, x_reg}) + $signed({{(XS-DX_WIDTH){dx_reg[DX_WIDTH-1]}}, dx_reg});
    if (x_sum < X_LO)      x_clamped = W_X'(X_MIN);
    else if (x_sum > X_HI) x_clamped = W_X'(X_MAX);
    else                   x_clamped = x_sum[W_X-1:0];
    y_sum = $signed({2'b00, y_reg}) + $signed({{(YS-DY_WIDTH){dy_reg[DY_WIDTH-1]}}, dy_reg});
    y_off_top    = y_sum[YS-1];
    y_off_bottom = !y_sum[YS-1] && (y_sum >= Y_LIM);
`ifdef GAME_SPRITE_METEOR_WRAP_EN
    y_wrap = W_Y'(y_sum - Y_LIM);
`endif
  end

  // Sprite state machine with registered position and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      x_reg         <= '0;
      y_reg         <= '0;
      dx_reg        <= '0;
      dy_reg        <= '0;
      fire_pending  <= 1'b0;
      active_reg    <= 1'b0;
      flying_reg    <= 1'b0;
      offscreen_reg <= 1'b0;
    end else begin
      offscreen_reg <= 1'b0;
      if (bus.load_dxy) begin
        dx_reg <= bus.load_dx;
        dy_reg <= bus.load_dy;
      end
      if (bus.load_xy) begin
        // A load overrides any motion scheduled for this tick.
        x_reg        <= bus.load_x;
        y_reg        <= bus.load_y;
        state        <= ARMED;
        fire_pending <= 1'b0;
        active_reg   <= 1'b1;
        flying_reg   <= 1'b0;
      end else begin
        case (state)
          ARMED: begin
            if (bus.mode == 2'd2 && bus.fire) fire_pending <= 1'b1;
            if (move) begin
              case (bus.mode)
                2'd0: x_reg <= x_clamped;
                2'd1: begin
                  if (y_off_top) begin
                    state         <= DONE;
                    active_reg    <= 1'b0;
                    offscreen_reg <= 1'b1;
                  end else if (y_off_bottom) begin
`ifdef GAME_SPRITE_METEOR_WRAP_EN
                    y_reg         <= y_wrap;
                    offscreen_reg <= 1'b1;
`else
                    state         <= DONE;
                    active_reg    <= 1'b0;
                    offscreen_reg <= 1'b1;
`endif
                  end else begin
                    y_reg <= y_sum[W_Y-1:0];
                  end
                end
                2'd2: begin
                  if (fire_pending || bus.fire) begin
                    // Launch tick: position holds, flight starts next tick.
                    state        <= FLYING;
                    flying_reg   <= 1'b1;
                    fire_pending <= 1'b0;
                  end else begin
                    x_reg <= x_clamped;
                  end
                end
                default: ;
              endcase
            end
          end
          FLYING: begin
            if (move) begin
              if (y_reg < B_SPEED) begin
                state         <= DONE;
                active_reg    <= 1'b0;
                flying_reg    <= 1'b0;
                offscreen_reg <= 1'b1;
              end else begin
                y_reg <= y_reg - B_SPEED;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.x         = x_reg;
  assign bus.y         = y_reg;
  assign bus.active    = active_reg;
  assign bus.flying    = flying_reg;
  assign bus.offscreen = offscreen_reg;

endmodule

// File: tb/tb_game_sprite_motion_ctrl.sv
// Directed bench for game_sprite_motion_ctrl with a 2-bit strobe divider
// (tick every 4th cycle). Table-driven vectors plus hand sequences for
// reset timing, bullet launch/flight and load-over-tick priority.
module tb_game_sprite_motion_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] tb_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0] mode;
    logic       ld_xy;
    int         lx;
    int         ly;
    logic       ld_dxy;
    logic [3:0] dx;
    logic [3:0] dy;
    logic       en;
    logic       fire;
    int         ticks;
    int         ex;
    int         ey;
    int         eact;
    int         efly;
    int         eoff;
  } vec_t;

  vec_t vecs[16];

  game_sprite_motion_ctrl_if ifc ();

  game_sprite_motion_ctrl #(.STROBE_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always #5 clk = ~clk;

  // Reference strobe counter: a tick occurs during any cycle where it reads 3.
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 2'd0;
    else     tb_cnt <= tb_cnt + 2'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input int eact, input int efly, input int eoff);
    check({tag, ".x"}, int'(ifc.x), ex);
    check({tag, ".y"}, int'(ifc.y), ey);
    check({tag, ".active"}, int'(ifc.active), eact);
    check({tag, ".flying"}, int'(ifc.flying), efly);
    check({tag, ".offscreen"}, int'(ifc.offscreen), eoff);
    $display("[TB] %s x=%0d y=%0d active=%0d flying=%0d offscreen=%0d",
             tag, ifc.x, ifc.y, ifc.active, ifc.flying, ifc.offscreen);
  endtask

  // Advance through n tick edges; returns 1 time unit after the last one.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      while (tb_cnt != 2'd3) @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one record's loads on an edge that is not a tick edge, then wait its ticks.
  task automatic apply_rec(input vec_t r);
    @(negedge clk);
    while (tb_cnt == 2'd3) @(negedge clk);
    ifc.mode     = r.mode;
    ifc.enable   = r.en;
    ifc.fire     = r.fire;
    ifc.load_xy  = r.ld_xy;
    ifc.load_x   = 10'(r.lx);
    ifc.load_y   = 9'(r.ly);
    ifc.load_dxy = r.ld_dxy;
    ifc.load_dx  = r.dx;
    ifc.load_dy  = r.dy;
    @(posedge clk);
    #1;
    ifc.load_xy  = 1'b0;
    ifc.load_dxy = 1'b0;
    wait_ticks(r.ticks);
  endtask

  task automatic fire_pulse_between_ticks();
    @(negedge clk);
    while (tb_cnt != 2'd1) @(negedge clk);
    ifc.fire = 1'b1;
    @(posedge clk);
    #1;
    ifc.fire = 1'b0;
  endtask

  initial begin
    vec_t b;
    // mode, ld_xy, lx, ly, ld_dxy, dx, dy, en, fire, ticks, ex, ey, act, fly, off
    vecs[0]  = '{2'd0, 1'b1, 428, 0,   1'b1, 4'h3, 4'h0, 1'b1, 1'b0, 1, 430, 0,   1, 0, 0};
    vecs[1]  = '{2'd0, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 430, 0,   1, 0, 0};
    vecs[2]  = '{2'd0, 1'b0, 0,   0,   1'b1, 4'hE, 4'h0, 1'b1, 1'b0, 1, 428, 0,   1, 0, 0};
    vecs[3]  = '{2'd0, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 426, 0,   1, 0, 0};
    vecs[4]  = '{2'd1, 1'b1, 100, 470, 1'b1, 4'h0, 4'h4, 1'b1, 1'b0, 1, 100, 474, 1, 0, 0};
    vecs[5]  = '{2'd1, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 100, 478, 1, 0, 0};
`ifdef GAME_SPRITE_METEOR_WRAP_EN
    vecs[6]  = '{2'd1, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 100, 2,   1, 0, 1};
    vecs[7]  = '{2'd1, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 100, 6,   1, 0, 0};
`else
    vecs[6]  = '{2'd1, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 100, 478, 0, 0, 1};
    vecs[7]  = '{2'd1, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 100, 478, 0, 0, 0};
`endif
    vecs[8]  = '{2'd0, 1'b1, 195, 0,   1'b1, 4'hC, 4'h0, 1'b1, 1'b0, 1, 192, 0,   1, 0, 0};
    vecs[9]  = '{2'd0, 1'b0, 0,   0,   1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1, 197, 0,   1, 0, 0};
    vecs[10] = '{2'd3, 1'b1, 50,  60,  1'b1, 4'h3, 4'h3, 1'b1, 1'b0, 1, 50,  60,  1, 0, 0};
    vecs[11] = '{2'd1, 1'b1, 50,  2,   1'b1, 4'h0, 4'hD, 1'b1, 1'b0, 1, 50,  2,   0, 0, 1};
    vecs[12] = '{2'd0, 1'b1, 300, 0,   1'b1, 4'h1, 4'h0, 1'b0, 1'b0, 8, 300, 0,   1, 0, 0};
    vecs[13] = '{2'd0, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1, 301, 0,   1, 0, 0};
    vecs[14] = '{2'd0, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 2, 303, 0,   1, 0, 0};
    vecs[15] = '{2'd0, 1'b0, 0,   0,   1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1, 304, 0,   1, 0, 0};

    // Inputs set up during reset so the first edge after release loads an armed player.
    ifc.mode = 2'd0; ifc.enable = 1'b1; ifc.fire = 1'b0;
    ifc.load_xy = 1'b1; ifc.load_x = 10'd200; ifc.load_y = 9'd0;
    ifc.load_dxy = 1'b1; ifc.load_dx = 4'h1; ifc.load_dy = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);

    // First tick is during cycle 3 after release, so motion lands on edge 4.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ifc.load_xy = 1'b0; ifc.load_dxy = 1'b0;
    check_all("first.edge1", 200, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_all("first.edge3", 200, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    check_all("first.edge4", 201, 0, 1, 0, 0);

    for (int i = 0; i < 16; i++) begin
      apply_rec(vecs[i]);
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey,
                vecs[i].eact, vecs[i].efly, vecs[i].eoff);
    end

    // Bullet: launch on the tick after a one-cycle fire pulse, then rise by 3.
    b = '{2'd2, 1'b1, 300, 10, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0};
    apply_rec(b);
    fire_pulse_between_ticks();
    check_all("bullet.pending", 300, 10, 1, 0, 0);
    wait_ticks(1);
    check_all("bullet.launch", 300, 10, 1, 1, 0);
    wait_ticks(1);
    check_all("bullet.y7", 300, 7, 1, 1, 0);
    wait_ticks(1);
    check_all("bullet.y4", 300, 4, 1, 1, 0);
    wait_ticks(1);
    check_all("bullet.y1", 300, 1, 1, 1, 0);
    wait_ticks(1);
    check_all("bullet.done", 300, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    check_all("bullet.after", 300, 1, 0, 0, 0);

    // Load in the same cycle as a tick while flying: load wins, no motion.
    apply_rec(b);
    fire_pulse_between_ticks();
    wait_ticks(1);
    wait_ticks(1);
    check_all("reload.fly", 300, 7, 1, 1, 0);
    @(negedge clk);
    while (tb_cnt != 2'd3) @(negedge clk);
    ifc.load_xy = 1'b1; ifc.load_x = 10'd250; ifc.load_y = 9'd100;
    @(posedge clk);
    #1;
    ifc.load_xy = 1'b0;
    check_all("reload.tick", 250, 100, 1, 0, 0);
    wait_ticks(1);
    check_all("reload.next", 250, 100, 1, 0, 0);

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_all("idle_hold", 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
